ifetch_pc: RTL and testbench

Instruction fetch stage directly upstream of the instruction-memory word-select decoder. Holds the program counter and drives the 4-bit word index (PC[5:2]) that the decoder expands to 16 one-hot word selects. Captures the returned instruction word into an output register and hands it to decode over a valid/ready handshake. Supports redirects from branch or jump, and flags fetches that fall outside the 16-word memory window.

---
 rtl/ifetch_pc_pkg.sv | 15 +
 rtl/ifetch_pc.sv | 83 ++++++++
 tb/tb_ifetch_pc.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pc_pkg.sv
// Shared constants and types for the instruction fetch PC stage.
// Default window geometry, reset PC, fetch FSM states and the NOP encoding.
package ifetch_pc_pkg;

   localparam int unsigned IMEM_WORDS_DEF = 16;
   localparam int unsigned IDX_W_DEF      = 4;
   localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

   typedef enum logic {
      FETCH = 1'b0,
      FAULT = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/ifetch_pc.sv
// Instruction fetch stage: holds the PC, drives the word index to the imem
// decoder and registers the returned word onto a valid/ready output slot.
module ifetch_pc
   import ifetch_pc_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int unsigned       IDX_W      = IDX_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RESET_PC_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   output logic [IDX_W-1:0]  imem_idx,
   input  logic [31:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic              fetch_fault
);

   localparam logic [ADDR_W-1:0] WINDOW_END = ADDR_W'(IMEM_WORDS * 4);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] out_pc_q, out_pc_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic              out_valid_q, out_valid_d;
   logic              slot_free;
   logic              in_window;

   assign slot_free = !out_valid_q || out_ready;
   assign in_window = (pc_q < WINDOW_END);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         out_pc_q    <= '0;
         out_instr_q <= NOP_INSTR;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_pc_q    <= out_pc_d;
         out_instr_q <= out_instr_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Redirect outranks everything, including a held instruction and FAULT.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_pc_d    = out_pc_q;
      out_instr_d = out_instr_q;
      out_valid_d = out_valid_q;
      if (redirect_valid) begin
         pc_d        = {redirect_pc[ADDR_W-1:2], 2'b00};
         out_valid_d = 1'b0;
         state_d     = FETCH;
      end else if (state_q == FETCH && slot_free) begin
         if (in_window) begin
            out_instr_d = imem_rdata;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + ADDR_W'(4);
         end else begin
            out_valid_d = 1'b0;
            state_d     = FAULT;
         end
      end
   end

   assign imem_idx    = pc_q[IDX_W+1:2];
   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_ifetch_pc.sv
// Directed self-checking bench for ifetch_pc against a 16-word memory model.
module tb_ifetch_pc;
   import ifetch_pc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  imem_idx;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fetch_fault;

   int checks   = 0;
   int failures = 0;

   ifetch_pc #(.ADDR_W(32), .IMEM_WORDS(16), .IDX_W(4), .RESET_PC(32'h0)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_idx       (imem_idx),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   assign imem_rdata = 32'h1000_0000 + {28'h0, imem_idx};

   // One active edge, then settle on the falling edge for sampling and driving.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      #12;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP_INSTR || out_pc !== 32'h0 ||
          imem_idx !== 4'd0 || fetch_fault !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: valid=%b instr=%h pc=%h idx=%0d fault=%b required 0/0/0/0/0",
                  out_valid, out_instr, out_pc, imem_idx, fetch_fault);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (imem_idx !== 4'd0) begin
         failures++;
         $display("FAIL first_idx: idx=%0d required 0", imem_idx);
      end
   endtask

   task automatic test_stream();
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 + i || out_pc !== 32'(4 * i)) begin
            failures++;
            $display("FAIL stream_%0d: valid=%b instr=%h pc=%h required 1/%h/%h",
                     i, out_valid, out_instr, out_pc, 32'h1000_0000 + i, 4 * i);
         end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 32'h1000_0002 || out_pc !== 32'h8 || imem_idx !== 4'd3) begin
            failures++;
            $display("FAIL stall_%0d: valid=%b instr=%h pc=%h idx=%0d required 1/10000002/8/3",
                     i, out_valid, out_instr, out_pc, imem_idx);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h1000_0003 || out_pc !== 32'hC) begin
         failures++;
         $display("FAIL stall_release: valid=%b instr=%h pc=%h required 1/10000003/c",
                  out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_redirect_held();
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h28;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || imem_idx !== 4'd10) begin
         failures++;
         $display("FAIL redirect_flush: valid=%b idx=%0d required 0/10", out_valid, imem_idx);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h1000_000A || out_pc !== 32'h28) begin
         failures++;
         $display("FAIL redirect_first: valid=%b instr=%h pc=%h required 1/1000000a/28",
                  out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_window_fault();
      out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h38;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(32'h38 + 4 * i) || out_instr !== 32'h1000_000E + i) begin
            failures++;
            $display("FAIL edge_fetch_%0d: valid=%b instr=%h pc=%h required 1/%h/%h",
                     i, out_valid, out_instr, out_pc, 32'h1000_000E + i, 32'h38 + 4 * i);
         end
      end
      step();
      checks++;
      if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL fault_enter: fault=%b valid=%b required 1/0", fetch_fault, out_valid);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'h3C) begin
            failures++;
            $display("FAIL fault_hold_%0d: fault=%b valid=%b pc=%h required 1/0/3c",
                     i, fetch_fault, out_valid, out_pc);
         end
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (fetch_fault !== 1'b0 || out_valid !== 1'b0 || imem_idx !== 4'd0) begin
         failures++;
         $display("FAIL fault_exit: fault=%b valid=%b idx=%0d required 0/0/0", fetch_fault, out_valid, imem_idx);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 || out_pc !== 32'h0) begin
         failures++;
         $display("FAIL fault_resume: valid=%b instr=%h pc=%h required 1/10000000/0",
                  out_valid, out_instr, out_pc);
      end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h13;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (imem_idx !== 4'd4 || fetch_fault !== 1'b0) begin
         failures++;
         $display("FAIL misalign_idx: idx=%0d fault=%b required 4/0", imem_idx, fetch_fault);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h1000_0004) begin
         failures++;
         $display("FAIL misalign_out: valid=%b pc=%h instr=%h required 1/10/10000004",
                  out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_async_reset();
      step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || imem_idx !== 4'd0) begin
         failures++;
         $display("FAIL async_reset: valid=%b instr=%h pc=%h idx=%0d required 0/0/0/0",
                  out_valid, out_instr, out_pc, imem_idx);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_instr !== 32'h1000_0000 + i || out_pc !== 32'(4 * i)) begin
            failures++;
            $display("FAIL reset_resume_%0d: valid=%b instr=%h pc=%h required 1/%h/%h",
                     i, out_valid, out_instr, out_pc, 32'h1000_0000 + i, 4 * i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_held();
      test_window_fault();
      test_misaligned();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
